// File: rtl/clock_step_controller.sv
// Debug clock-step sequencer: drives the enable of an AND-type clock gate for
// free-run, halt, N-cycle single-step and breakpoint halt of the core clock.
module clock_step_controller #(
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned CNT_W     = 32,
    parameter bit          RESET_RUN = 1'b0
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              breakpoint_hit,
    output logic              clk_enable,
    output logic              running,
    output logic              bp_halted,
    output logic [CNT_W-1:0]  gated_cycles
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [STEP_W-1:0] remaining;
    logic [STEP_W-1:0] remaining_next;
    logic [STEP_W-1:0] step_load;
    logic              bp_next;
    logic              step_req_d;
    logic              step_edge;
    logic              bp_seen;
    logic              en_next;

    assign step_edge = step_req & ~step_req_d;
    assign bp_seen   = breakpoint_hit & clk_enable;
    assign step_load = (step_count == '0) ? STEP_W'(1) : step_count;
    assign en_next   = (state == RUN) || ((state == STEP) && (remaining != '0));

    // State register; step_req_d resets high so a held step_req is not an edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            if (RESET_RUN) state <= RUN;
            else           state <= HALT;
            remaining  <= '0;
            bp_halted  <= 1'b0;
            running    <= RESET_RUN;
            step_req_d <= 1'b1;
        end else begin
            state      <= state_next;
            remaining  <= remaining_next;
            bp_halted  <= bp_next;
            running    <= (state_next != HALT);
            step_req_d <= step_req;
        end
    end

    // Next-state: halt_req > breakpoint > run_req > step edge.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        bp_next        = bp_halted;
        case (state)
            HALT: begin
                if (!halt_req) begin
                    if (run_req) begin
                        state_next = RUN;
                        bp_next    = 1'b0;
                    end else if (step_edge) begin
                        state_next     = STEP;
                        remaining_next = step_load;
                        bp_next        = 1'b0;
                    end
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_next = HALT;
                end else if (bp_seen) begin
                    state_next = HALT;
                    bp_next    = 1'b1;
                end
            end
            STEP: begin
                if (halt_req) begin
                    state_next     = HALT;
                    remaining_next = '0;
                end else if (bp_seen) begin
                    state_next     = HALT;
                    remaining_next = '0;
                    bp_next        = 1'b1;
                end else if (run_req) begin
                    state_next     = RUN;
                    remaining_next = '0;
                end else if (clk_enable) begin
                    remaining_next = remaining - STEP_W'(1);
                    if (remaining == STEP_W'(1)) state_next = HALT;
                end
            end
            default: begin
                state_next     = HALT;
                remaining_next = '0;
            end
        endcase
    end

    // Enable updates on the falling edge so the gated clock cannot glitch.
    always_ff @(negedge clk_in or posedge reset) begin
        if (reset) clk_enable <= 1'b0;
        else       clk_enable <= en_next;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)           gated_cycles <= '0;
        else if (clk_enable) gated_cycles <= gated_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_clock_step_controller.sv
// Scoreboard bench for clock_step_controller: directed stimulus queues expected
// outputs per cycle; a negedge monitor pops and compares them.
module tb_clock_step_controller;

    localparam int unsigned STEP_W = 8;
    localparam int unsigned CNT_W  = 8;

    logic              clk;
    logic              reset;
    logic              run_req;
    logic              halt_req;
    logic              step_req;
    logic [STEP_W-1:0] step_count;
    logic              breakpoint_hit;
    logic              clk_enable;
    logic              running;
    logic              bp_halted;
    logic [CNT_W-1:0]  gated_cycles;

    clock_step_controller #(
        .STEP_W    (STEP_W),
        .CNT_W     (CNT_W),
        .RESET_RUN (1'b0)
    ) dut (
        .clk_in         (clk),
        .reset          (reset),
        .run_req        (run_req),
        .halt_req       (halt_req),
        .step_req       (step_req),
        .step_count     (step_count),
        .breakpoint_hit (breakpoint_hit),
        .clk_enable     (clk_enable),
        .running        (running),
        .bp_halted      (bp_halted),
        .gated_cycles   (gated_cycles)
    );

    typedef struct {
        int               cyc;
        string            name;
        logic             en;
        logic [CNT_W-1:0] gc;
        logic             run;
        logic             bp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected values are checked after the negedge that follows posedge 'cyc'.
    task automatic expect_at(input int at, input string name, input logic en,
                             input logic [CNT_W-1:0] gc, input logic run, input logic bp);
        exp_t e;
        e.cyc = at; e.name = name; e.en = en; e.gc = gc; e.run = run; e.bp = bp;
        sb.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    always @(negedge clk) begin
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            tests++;
            if (mon_e.cyc < cyc) begin
                fails++;
                $display("FAIL %s: check skipped, due cycle %0d, now %0d", mon_e.name, mon_e.cyc, cyc);
            end else if ({clk_enable, gated_cycles, running, bp_halted} !==
                         {mon_e.en, mon_e.gc, mon_e.run, mon_e.bp}) begin
                fails++;
                $display("FAIL %s: got en=%b gc=%0d run=%b bp=%b, want en=%b gc=%0d run=%b bp=%b",
                         mon_e.name, clk_enable, gated_cycles, running, bp_halted,
                         mon_e.en, mon_e.gc, mon_e.run, mon_e.bp);
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        step_count = '0; breakpoint_hit = 1'b0;
        tick(3);
        reset = 1'b0;

        // Idle after reset: halted, nothing gated
        t = cyc;
        expect_at(t,      "reset_idle",   1'b0, 8'd0, 1'b0, 1'b0);
        expect_at(t + 20, "idle_20",      1'b0, 8'd0, 1'b0, 1'b0);
        tick(22);

        // Step of 5
        t = cyc;
        step_count = 8'd5; step_req = 1'b1;
        expect_at(t + 1, "step5_start",   1'b1, 8'd0, 1'b1, 1'b0);
        expect_at(t + 5, "step5_last",    1'b1, 8'd4, 1'b1, 1'b0);
        expect_at(t + 6, "step5_done",    1'b0, 8'd5, 1'b0, 1'b0);
        tick(1); step_req = 1'b0;
        tick(8);

        // Step count 0 acts as 1; held step_req gives a single step
        t = cyc;
        step_count = 8'd0; step_req = 1'b1;
        expect_at(t + 1,  "step0_start",  1'b1, 8'd5, 1'b1, 1'b0);
        expect_at(t + 2,  "step0_done",   1'b0, 8'd6, 1'b0, 1'b0);
        expect_at(t + 12, "step_held",    1'b0, 8'd6, 1'b0, 1'b0);
        tick(12); step_req = 1'b0;
        tick(2);

        // Run, halt on 7th gated edge, then run+halt together stays halted
        t = cyc;
        run_req = 1'b1;
        expect_at(t + 7,  "run_pre_halt", 1'b1, 8'd12, 1'b1, 1'b0);
        expect_at(t + 8,  "run_halted",   1'b0, 8'd13, 1'b0, 1'b0);
        expect_at(t + 11, "run_and_halt", 1'b0, 8'd13, 1'b0, 1'b0);
        tick(1); run_req = 1'b0;
        tick(6); halt_req = 1'b1;
        tick(1); run_req = 1'b1;
        tick(3); run_req = 1'b0; halt_req = 1'b0;
        tick(2);

        // Breakpoint on gated edge 12
        t = cyc;
        run_req = 1'b1;
        expect_at(t + 12, "bp_pre",       1'b1, 8'd24, 1'b1, 1'b0);
        expect_at(t + 13, "bp_halt",      1'b0, 8'd25, 1'b0, 1'b1);
        tick(1); run_req = 1'b0;
        tick(11); breakpoint_hit = 1'b1;
        tick(1); breakpoint_hit = 1'b0;
        tick(2);

        // Step clears bp_halted; breakpoint while halted is ignored
        t = cyc;
        step_count = 8'd2; step_req = 1'b1;
        expect_at(t + 1, "bp_clear",      1'b1, 8'd25, 1'b1, 1'b0);
        expect_at(t + 3, "step2_done",    1'b0, 8'd27, 1'b0, 1'b0);
        expect_at(t + 7, "bp_ignored",    1'b0, 8'd27, 1'b0, 1'b0);
        tick(1); step_req = 1'b0;
        tick(3); breakpoint_hit = 1'b1;
        tick(3); breakpoint_hit = 1'b0;
        tick(2);

        // Reset mid-step with 3 remaining; step_req held through reset is no edge
        t = cyc;
        step_count = 8'd6; step_req = 1'b1;
        expect_at(t + 3,  "mid_step",     1'b1, 8'd29, 1'b1, 1'b0);
        expect_at(t + 4,  "reset_step",   1'b0, 8'd0,  1'b0, 1'b0);
        expect_at(t + 5,  "reset_hold",   1'b0, 8'd0,  1'b0, 1'b0);
        expect_at(t + 10, "held_no_step", 1'b0, 8'd0,  1'b0, 1'b0);
        tick(1); step_req = 1'b0;
        tick(3); reset = 1'b1; step_req = 1'b1;
        tick(2); reset = 1'b0;
        tick(4); step_req = 1'b0;
        tick(2);

        // Counter wrap at 2^CNT_W
        t = cyc;
        run_req = 1'b1;
        expect_at(t + 256, "wrap_max",    1'b1, 8'd255, 1'b1, 1'b0);
        expect_at(t + 257, "wrap_zero",   1'b1, 8'd0,   1'b1, 1'b0);
        expect_at(t + 258, "wrap_halt",   1'b0, 8'd1,   1'b0, 1'b0);
        tick(1); run_req = 1'b0;
        tick(256); halt_req = 1'b1;
        tick(1); halt_req = 1'b0;
        tick(2);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d checks never reached", sb.size());
            tests += sb.size();
            fails += sb.size();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
